text_buf_ctrl: RTL and testbench
================================

TEXT_BUF_CTRL -- requirements
Module: text_buf_ctrl

Interface
REQ-001 SHALL have parameter MEMSIZE, default 128, meaning the number of character cells.
REQ-002 SHALL have parameter ROW_LEN, default 32, meaning cells per text row (a power of two).
REQ-003 SHALL have parameter BLANK, default 16'h0020, meaning the blank cell code.
REQ-004 SHALL have clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have reset  input  1  meaning synchronous, active-high reset.
REQ-006 SHALL have rx_valid  input  1  meaning a UART byte is available.
REQ-007 SHALL have rx_data  input  8  meaning the UART byte.
REQ-008 SHALL have rx_ready  output  1  meaning the controller accepts rx_data this cycle.
REQ-009 SHALL have clear_req  input  1  meaning a request to blank the whole buffer.
REQ-010 SHALL have wr_en  output  1  meaning character-memory write strobe, one cycle.
REQ-011 SHALL have wr_addr  output  7  meaning character-memory write address.
REQ-012 SHALL have wr_data  output  16  meaning character-memory write data.
REQ-013 SHALL have cursor  output  7  meaning the next write position.
REQ-014 SHALL have busy  output  1  meaning a clear sweep is in progress.
REQ-015 SHALL have err  output  1  meaning a one-cycle pulse on a malformed 3-byte sequence.

Function
REQ-016 SHALL implement states IDLE, UTF_B2, UTF_B3 and CLEAR.
REQ-017 SHALL compute rx_ready combinationally as (state != CLEAR) && !clear_req; a byte is accepted only when rx_valid && rx_ready.
REQ-018 SHALL drive wr_en, wr_addr and wr_data as registers, asserted in the cycle after the accepting edge (latency 1); wr_en SHALL be low in all other cycles outside CLEAR.
REQ-019 SHALL, in IDLE on byte 0x0D, set cursor = ((cursor/ROW_LEN)+1)*ROW_LEN, wrapping to 0 when the result is >= MEMSIZE, with no write.
REQ-020 SHALL, in IDLE on byte 0x7F, set cursor = (cursor-1) mod MEMSIZE and write BLANK at the new cursor; from cursor 0 the target is 127.
REQ-021 SHALL, in IDLE on byte 0xE0, latch nothing else, issue no write, and go to UTF_B2.
REQ-022 SHALL, in IDLE on any other byte, write {9'b0, rx_data[6:0]} at cursor, then cursor = cursor+1 mod MEMSIZE.
REQ-023 SHALL, in UTF_B2 on a byte matching 10xxxxxx, latch it as b2 and go to UTF_B3.
REQ-024 SHALL, in UTF_B3 on a byte matching 10xxxxxx, write {b2, byte} at cursor, advance cursor mod MEMSIZE, and go to IDLE.
REQ-025 SHALL, in UTF_B2 or UTF_B3 on a byte not matching 10xxxxxx, discard the sequence and that byte, pulse err for one cycle after the edge, perform no write or cursor change, and go to IDLE.
REQ-026 SHALL, on clear_req in any non-CLEAR state, abandon any partial sequence and enter CLEAR on the next edge, with cursor set to 0.
REQ-027 SHALL, in CLEAR, write BLANK at addresses 0 through MEMSIZE-1, one per cycle in ascending order (MEMSIZE consecutive wr_en cycles), then return to IDLE.
REQ-028 SHALL hold busy high for exactly the cycles the controller is in CLEAR.
REQ-029 SHALL ignore clear_req while in CLEAR; the sweep is not restarted.
REQ-030 SHALL give clear_req priority when clear_req and rx_valid are both high; that byte is not accepted because rx_ready is 0.
REQ-031 SHALL keep cursor within 0..MEMSIZE-1 at all times.

Reset
REQ-032 SHALL, while reset is high at an edge, force state to IDLE, cursor to 0, wr_en to 0, wr_addr to 0, wr_data to BLANK, busy to 0, err to 0 and b2 to 0.
REQ-033 SHALL abort any UTF sequence or CLEAR sweep in progress on reset, with no write in the cycle after the reset edge.
REQ-034 SHALL have reset take priority over clear_req and rx_valid.

Verification
REQ-035 SHALL verify: at cursor 0, bytes 'A' (0x41) then 'B' (0x42) -> writes (0,0x0041) and (1,0x0042), each one cycle after acceptance; cursor ends at 2.
REQ-036 SHALL verify: at cursor 5, byte 0x0D -> cursor 32 with no wr_en; at cursor 100, byte 0x0D -> cursor 0.
REQ-037 SHALL verify: at cursor 0, byte 0x7F -> write (127,0x0020); cursor ends at 127.
REQ-038 SHALL verify: bytes E0 B8 81 at cursor 3 -> a single write (3,0xB881) and cursor 4; bytes E0 41 -> err pulse, no write, and state IDLE.
REQ-039 SHALL verify: clear_req with rx_valid high -> rx_ready 0, 128 consecutive BLANK writes to addresses 0..127, busy high for 128 cycles, cursor 0, and the held byte accepted afterwards.
REQ-040 SHALL verify: reset asserted during cycle 40 of a clear sweep -> wr_en 0, busy 0, cursor 0 and state IDLE on the next cycle.

Source files
------------

// File: rtl/text_buf_ctrl.sv
// Purpose  : UART-to-character-memory controller for a text display buffer.
// Latency  : one cycle from byte acceptance to the write strobe; clear sweeps one cell per cycle.
// Backpress: rx_ready is low during a clear sweep and whenever clear_req is high.
// Ports    : clk/reset (sync, active-high); rx_valid/rx_data/rx_ready byte stream in;
//            clear_req in; wr_en/wr_addr/wr_data memory write port; cursor, busy, err status.
module text_buf_ctrl #(
  parameter int          MEMSIZE = 128,
  parameter int          ROW_LEN = 32,
  parameter logic [15:0] BLANK   = 16'h0020,
  localparam int         AW      = $clog2(MEMSIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  input  logic          clear_req,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic [AW-1:0] cursor,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {IDLE, UTF_B2, UTF_B3, CLEAR} state_t;

  localparam logic [AW-1:0] LAST     = AW'(MEMSIZE - 1);
  localparam logic [AW:0]   ROW_MASK = (AW + 1)'(ROW_LEN - 1);
  localparam logic [AW:0]   ROW_STEP = (AW + 1)'(ROW_LEN);
  localparam logic [AW:0]   MEM_LIM  = (AW + 1)'(MEMSIZE);

  state_t        state;
  logic [7:0]    b2;
  logic          accept;
  logic          is_cont;
  logic [AW:0]   nl_sum;
  logic [AW-1:0] cur_nl;
  logic [AW-1:0] cur_inc;
  logic [AW-1:0] cur_dec;

  assign rx_ready = (state != CLEAR) && !clear_req;
  assign accept   = rx_valid && rx_ready;
  assign is_cont  = (rx_data[7:6] == 2'b10);

  // Start of the next row; one extra bit so the end-of-buffer overflow is visible.
  assign nl_sum  = ({1'b0, cursor} & ~ROW_MASK) + ROW_STEP;
  assign cur_nl  = (nl_sum >= MEM_LIM) ? '0 : nl_sum[AW-1:0];
  assign cur_inc = (cursor == LAST) ? '0 : cursor + AW'(1);
  assign cur_dec = (cursor == '0) ? LAST : cursor - AW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cursor  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= BLANK;
      busy    <= 1'b0;
      err     <= 1'b0;
      b2      <= '0;
    end else begin
      wr_en <= 1'b0;
      err   <= 1'b0;
      if (state == CLEAR) begin
        // wr_addr doubles as the sweep counter; clear_req is ignored here.
        if (wr_addr == LAST) begin
          state <= IDLE;
          busy  <= 1'b0;
        end else begin
          wr_en   <= 1'b1;
          wr_addr <= wr_addr + AW'(1);
          wr_data <= BLANK;
        end
      end else if (clear_req) begin
        // First sweep write (address 0) goes out in the first CLEAR cycle.
        state   <= CLEAR;
        busy    <= 1'b1;
        cursor  <= '0;
        wr_en   <= 1'b1;
        wr_addr <= '0;
        wr_data <= BLANK;
      end else if (accept) begin
        if (state == IDLE) begin
          case (rx_data)
            8'h0D: cursor <= cur_nl;
            8'h7F: begin
              cursor  <= cur_dec;
              wr_en   <= 1'b1;
              wr_addr <= cur_dec;
              wr_data <= BLANK;
            end
            8'hE0: state <= UTF_B2;
            default: begin
              cursor  <= cur_inc;
              wr_en   <= 1'b1;
              wr_addr <= cursor;
              wr_data <= {9'b0, rx_data[6:0]};
            end
          endcase
        end else if (!is_cont) begin
          // Malformed continuation byte: drop the whole sequence.
          state <= IDLE;
          err   <= 1'b1;
        end else if (state == UTF_B2) begin
          b2    <= rx_data;
          state <= UTF_B3;
        end else begin
          cursor  <= cur_inc;
          wr_en   <= 1'b1;
          wr_addr <= cursor;
          wr_data <= {b2, rx_data};
          state   <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_text_buf_ctrl.sv
// Purpose  : self-checking bench for text_buf_ctrl; directed bytes, scoreboarded write/err events.
// Latency  : expects every write or err pulse exactly one cycle after its causing edge.
// Backpress: byte driver holds rx_valid until rx_ready is seen high (bounded wait).
module tb_text_buf_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        clear_req;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [15:0] wr_data;
  logic [6:0]  cursor;
  logic        busy;
  logic        err;

  text_buf_ctrl dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .clear_req(clear_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cursor(cursor), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_err;
    logic [6:0]  addr;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc = cyc + 1;

  // Monitor: every write strobe or err pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (wr_en === 1'b1 || err === 1'b1) begin
      ev_t e;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d actual wr_en=%0b addr=%0d data=%h err=%0b required none",
                 cyc, wr_en, wr_addr, wr_data, err);
      end else begin
        e = q.pop_front();
        if (e.is_err ? !(err === 1'b1 && wr_en === 1'b0 && cyc == e.cyc)
                     : !(wr_en === 1'b1 && err === 1'b0 && wr_addr === e.addr &&
                         wr_data === e.data && cyc == e.cyc)) begin
          failures++;
          $display("FAIL event cyc=%0d actual wr_en=%0b addr=%0d data=%h err=%0b required cyc=%0d is_err=%0b addr=%0d data=%h",
                   cyc, wr_en, wr_addr, wr_data, err, e.cyc, e.is_err, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // kind: 0 = no event, 1 = write (a,d), 2 = err pulse
  task automatic send(input logic [7:0] b, input int kind, input logic [6:0] a, input logic [15:0] d);
    bit done = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    for (int n = 0; n < 300 && !done; n++) begin
      if (rx_ready) begin
        if (kind == 1) q.push_back('{1'b0, a, d, cyc + 1});
        else if (kind == 2) q.push_back('{1'b1, 7'd0, 16'd0, cyc + 1});
        done = 1;
      end
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout byte=%h actual=not_accepted required=accepted", b);
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; clear_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wr_en",    {31'd0, wr_en}, 32'd0);
    chk("reset_wr_addr",  {25'd0, wr_addr}, 32'd0);
    chk("reset_wr_data",  {16'd0, wr_data}, 32'h0020);
    chk("reset_cursor",   {25'd0, cursor}, 32'd0);
    chk("reset_busy",     {31'd0, busy}, 32'd0);
    chk("reset_err",      {31'd0, err}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_rx_ready",  {31'd0, rx_ready}, 32'd1);

    // Plain characters
    send(8'h41, 1, 7'd0, 16'h0041);
    send(8'h42, 1, 7'd1, 16'h0042);
    chk("cursor_after_AB", {25'd0, cursor}, 32'd2);
    send(8'h43, 1, 7'd2, 16'h0043);
    send(8'h44, 1, 7'd3, 16'h0044);
    send(8'h45, 1, 7'd4, 16'h0045);
    chk("cursor_5", {25'd0, cursor}, 32'd5);

    // Carriage return
    send(8'h0D, 0, 7'd0, 16'd0);
    chk("cr_from_5", {25'd0, cursor}, 32'd32);
    chk("cr_no_write", {31'd0, wr_en}, 32'd0);
    send(8'h0D, 0, 7'd0, 16'd0);
    send(8'h0D, 0, 7'd0, 16'd0);
    chk("cr_to_96", {25'd0, cursor}, 32'd96);
    for (int i = 0; i < 4; i++) send(8'h30 + 8'(i), 1, 7'(96 + i), 16'h0030 + 16'(i));
    chk("cursor_100", {25'd0, cursor}, 32'd100);
    send(8'h0D, 0, 7'd0, 16'd0);
    chk("cr_wrap_from_100", {25'd0, cursor}, 32'd0);

    // Backspace from 0 wraps to 127
    send(8'h7F, 1, 7'd127, 16'h0020);
    chk("bs_from_0", {25'd0, cursor}, 32'd127);
    send(8'h77, 1, 7'd127, 16'h0077);
    chk("inc_wrap_127", {25'd0, cursor}, 32'd0);
    send(8'h61, 1, 7'd0, 16'h0061);
    send(8'h62, 1, 7'd1, 16'h0062);
    send(8'h63, 1, 7'd2, 16'h0063);

    // Three-byte sequence
    send(8'hE0, 0, 7'd0, 16'd0);
    send(8'hB8, 0, 7'd0, 16'd0);
    send(8'h81, 1, 7'd3, 16'hB881);
    chk("utf_cursor", {25'd0, cursor}, 32'd4);

    // Malformed: bad second byte, then bad third byte
    send(8'hE0, 0, 7'd0, 16'd0);
    send(8'h41, 2, 7'd0, 16'd0);
    chk("bad_b2_cursor", {25'd0, cursor}, 32'd4);
    send(8'h5A, 1, 7'd4, 16'h005A);
    send(8'hE0, 0, 7'd0, 16'd0);
    send(8'hB8, 0, 7'd0, 16'd0);
    send(8'h00, 2, 7'd0, 16'd0);
    chk("bad_b3_cursor", {25'd0, cursor}, 32'd5);
    send(8'hC1, 1, 7'd5, 16'h0041);
    chk("cursor_6", {25'd0, cursor}, 32'd6);

    // Clear with a byte held on rx_valid
    rx_valid = 1'b1; rx_data = 8'h51; clear_req = 1'b1;
    #1;
    chk("clear_rx_ready_low", {31'd0, rx_ready}, 32'd0);
    for (int k = 0; k < 128; k++) q.push_back('{1'b0, 7'(k), 16'h0020, cyc + 1 + k});
    @(posedge clk); #1;
    clear_req = 1'b0;
    chk("clear_cursor", {25'd0, cursor}, 32'd0);
    cnt = 0;
    while (busy && cnt < 300) begin
      cnt++;
      clear_req = (cnt == 60);  // a request mid-sweep must not restart it
      @(posedge clk); #1;
    end
    clear_req = 1'b0;
    chk("busy_cycles", cnt, 32'd128);
    chk("post_clear_rx_ready", {31'd0, rx_ready}, 32'd1);
    q.push_back('{1'b0, 7'd0, 16'h0051, cyc + 1});
    @(posedge clk); #1;
    rx_valid = 1'b0;
    chk("held_byte_cursor", {25'd0, cursor}, 32'd1);

    // Reset during cycle 40 of a sweep
    clear_req = 1'b1;
    for (int k = 0; k < 40; k++) q.push_back('{1'b0, 7'(k), 16'h0020, cyc + 1 + k});
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (39) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_sweep_wr_en",  {31'd0, wr_en}, 32'd0);
    chk("rst_sweep_busy",   {31'd0, busy}, 32'd0);
    chk("rst_sweep_cursor", {25'd0, cursor}, 32'd0);
    chk("rst_sweep_ready",  {31'd0, rx_ready}, 32'd1);
    reset = 1'b0;
    send(8'h58, 1, 7'd0, 16'h0058);
    chk("after_rst_cursor", {25'd0, cursor}, 32'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
